id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Next-generation RV32I decode stage: full RV32I decode plus a registered ID/EX pipeline register with valid/ready handshake.
- Operand forwarding from NUM_FWD parametrised downstream sources, load-use hazard stall, and flush.
- Sits between the IF/ID register and the ex unit; its registered outputs feed ex directly.

Parameters:
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest (ex), higher = older (mem, wb...).
- RESET_PC, 32'h0, value of pc_o after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush_i  in  1  kill the held output and the current input (branch mispredict)
- in_valid_i  in  1  pc_i/inst_i valid
- in_ready_o  out  1  stage accepts input this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- reg1_addr_o  out  5  regfile read address rs1 (combinational, inst_i[19:15])
- reg2_addr_o  out  5  regfile read address rs2 (inst_i[24:20])
- reg1_data_i  in  32  regfile rs1 data, same cycle
- reg2_data_i  in  32  regfile rs2 data, same cycle
- fwd_wreg_i  in  NUM_FWD  source k writes a register
- fwd_pending_i  in  NUM_FWD  source k's data not yet available (load in ex)
- fwd_wd_i  in  5*NUM_FWD  source k destination, slice [5k+4:5k]
- fwd_wdata_i  in  32*NUM_FWD  source k data, slice [32k+31:32k]
- out_valid_o  out  1  registered outputs valid
- out_ready_i  in  1  ex accepts
- op_class_o  out  4  0 NOP, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP
- funct3_o  out  3  inst[14:12]
- alt_o  out  1  inst[30] for SUB/SRA/SRAI, else 0
- rs1_val_o  out  32  resolved rs1 operand
- rs2_val_o  out  32  resolved rs2 operand
- imm_o  out  32  sign-extended immediate per format
- rd_o  out  5  destination
- wreg_o  out  1  writes rd
- pc_o  out  32  pc of held instruction
- illegal_o  out  1  held instruction illegal

Behaviour:
- Reset: rst is synchronous, active-high. On reset: out_valid_o=0, op_class_o=0, funct3_o=0, alt_o=0, rs1_val_o=0, rs2_val_o=0, imm_o=0, rd_o=0, wreg_o=0, illegal_o=0, pc_o=RESET_PC. in_ready_o is combinational and is 0 while rst=1.
- Read flags per class:
  - rs1 read: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 read: BRANCH, STORE, OP.
- Immediates:
  - I: sext inst[31:20].
  - S: sext {inst[31:25], inst[11:7]}.
  - B: sext {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'h0}.
  - J: sext {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: imm=0.
  - Shift-immediates: imm = {27'h0, inst[24:20]}.
- wreg_o=1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP when rd≠0; 0 otherwise.
- Illegal, which forces op_class=0, wreg=0, illegal=1 in the registered output:
  - unknown opcode;
  - SLLI with funct7≠0;
  - SRLI/SRAI with funct7 not 0x00 or 0x20;
  - OP with funct7 not 0x00, or not 0x20 with funct3 in {000, 101};
  - JALR with funct3≠0;
  - BRANCH with funct3 in {010, 011};
  - LOAD with funct3 in {011, 110, 111};
  - STORE with funct3 >= 011.
- Operand resolution, per source operand, combinational, in priority order:
  1. addr==0 -> 0.
  2. Lowest k with fwd_wreg_i[k] and fwd_wd_i[k]==addr: take fwd_wdata_i[k].
  3. No match: take regfile data.
  4. Operand not read: value 0.
- Hazard: operand read, addr≠0, and the selected (lowest matching) k has fwd_pending_i[k]=1.
- Handshake:
  - in_ready_o = !rst & !hazard & (!out_valid_o | out_ready_i).
  - Transfer = in_valid_i & in_ready_o & !flush_i. On transfer, all outputs load at the next edge and out_valid_o becomes 1.
  - Else, if out_ready_i=1, out_valid_o becomes 0; other outputs hold.
  - While out_valid_o & !out_ready_i, all outputs hold bit-stable.
  - A hazard blocks only acceptance; a held output may still drain.
- flush_i: next edge out_valid_o=0 and no capture, regardless of other inputs. Data registers may hold. flush with rst: rst wins (same result).
- Throughput: one instruction per cycle when there is no hazard and out_ready_i=1. Latency: one cycle from accept to out_valid_o.

Test Plan:
- Reset, then inst 0xFFF00093 (ADDI x1,x0,-1), pc 0x100, out_ready=1 -> next cycle out_valid=1, class 8, imm 0xFFFFFFFF, rs1_val 0, rd 1, wreg 1, pc_o 0x100.
- inst 0x002081B3 (ADD x3,x1,x2), regfile rs1=5, rs2=7, fwd0 {wreg=1, wd=1, data=0x1234}, fwd1 {wreg=1, wd=1, data=0x9} -> rs1_val 0x1234, rs2_val 7, alt 0.
- Same ADD with fwd0 {wreg=1, wd=2, pending=1} for 2 cycles -> in_ready=0 both cycles, out_valid drops to 0. Pending then cleared with data 0x55 -> accepted, rs2_val 0x55.
- inst 0xFE000EE3 (BEQ x0,x0,-4) -> class 5, imm 0xFFFFFFFC, wreg 0. inst 0x008000EF (JAL x1,+8) -> class 3, imm 8, wreg 1.
- Backpressure: out_ready=0 for 3 cycles with a valid held -> outputs stable, in_ready=0. Raising flush_i -> out_valid=0 next cycle and the input presented that cycle is dropped.
- inst 0x4000D0B3 with funct7 = 0x21 variant (0x4200D0B3) -> illegal_o=1, class 0, wreg 0. 0x4000D0B3 (SRA) -> class 9, alt 1.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with operand forwarding, load-use stall and a registered
// ID/EX output stage guarded by a valid/ready handshake.
module id_stage_pipe #(
    parameter int          NUM_FWD  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             pc_i,
    input  logic [31:0]             inst_i,
    output logic [4:0]              reg1_addr_o,
    output logic [4:0]              reg2_addr_o,
    input  logic [31:0]             reg1_data_i,
    input  logic [31:0]             reg2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_wreg_i,
    input  logic [NUM_FWD-1:0]      fwd_pending_i,
    input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
    input  logic [32*NUM_FWD-1:0]   fwd_wdata_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [3:0]              op_class_o,
    output logic [2:0]              funct3_o,
    output logic                    alt_o,
    output logic [31:0]             rs1_val_o,
    output logic [31:0]             rs2_val_o,
    output logic [31:0]             imm_o,
    output logic [4:0]              rd_o,
    output logic                    wreg_o,
    output logic [31:0]             pc_o,
    output logic                    illegal_o
);

    typedef enum logic [3:0] {
        CLS_NOP = 4'd0, CLS_LUI = 4'd1, CLS_AUIPC = 4'd2, CLS_JAL = 4'd3, CLS_JALR = 4'd4,
        CLS_BRANCH = 4'd5, CLS_LOAD = 4'd6, CLS_STORE = 4'd7, CLS_OP_IMM = 4'd8, CLS_OP = 4'd9
    } op_class_e;

    typedef struct packed {
        logic        pending;
        logic [31:0] data;
    } operand_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign funct7      = inst_i[31:25];
    assign reg1_addr_o = inst_i[19:15];
    assign reg2_addr_o = inst_i[24:20];

    op_class_e   class_raw, class_d;
    logic        illegal_d, alt_d, wreg_d, rs1_read, rs2_read, hazard, xfer;
    logic [31:0] imm_d, rs1_val_d, rs2_val_d;
    operand_t    op1, op2;

    // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        class_raw = CLS_NOP;
        illegal_d = 1'b0;
        case (opcode)
            OPC_LUI:    class_raw = CLS_LUI;
            OPC_AUIPC:  class_raw = CLS_AUIPC;
            OPC_JAL:    class_raw = CLS_JAL;
            OPC_JALR: begin
                class_raw = CLS_JALR;
                illegal_d = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                class_raw = CLS_BRANCH;
                illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                class_raw = CLS_LOAD;
                illegal_d = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            OPC_STORE: begin
                class_raw = CLS_STORE;
                illegal_d = (funct3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                class_raw = CLS_OP_IMM;
                if (funct3 == 3'b001)      illegal_d = (funct7 != 7'h00);
                else if (funct3 == 3'b101) illegal_d = !((funct7 == 7'h00) || (funct7 == 7'h20));
            end
            OPC_OP: begin
                class_raw = CLS_OP;
                illegal_d = !((funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default:    illegal_d = 1'b1;
        endcase
        class_d = illegal_d ? CLS_NOP : class_raw;
    end

    always_comb begin
        imm_d = 32'h0;
        case (class_d)
            CLS_LUI, CLS_AUIPC: imm_d = {inst_i[31:12], 12'h0};
            CLS_JAL:    imm_d = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            CLS_JALR, CLS_LOAD: imm_d = {{20{inst_i[31]}}, inst_i[31:20]};
            CLS_BRANCH: imm_d = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            CLS_STORE:  imm_d = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            CLS_OP_IMM: imm_d = (funct3[1:0] == 2'b01) ? {27'h0, inst_i[24:20]}
                                                       : {{20{inst_i[31]}}, inst_i[31:20]};
            default:    imm_d = 32'h0;
        endcase
    end

    assign alt_d = ((class_d == CLS_OP) && ((funct3 == 3'b000) || (funct3 == 3'b101)) ||
                    (class_d == CLS_OP_IMM) && (funct3 == 3'b101)) ? inst_i[30] : 1'b0;
    assign wreg_d = (inst_i[11:7] != 5'd0) &&
                    (class_d inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_OP});
    assign rs1_read = class_d inside {CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP};
    assign rs2_read = class_d inside {CLS_BRANCH, CLS_STORE, CLS_OP};

    // Youngest matching source (lowest index) wins; x0 always reads zero and never stalls.
    function automatic operand_t resolve(input logic [4:0] addr, input logic [31:0] rf_data);
        operand_t r;
        logic     found;
        r     = '{pending: 1'b0, data: rf_data};
        found = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (!found && fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == addr)) begin
                found     = 1'b1;
                r.data    = fwd_wdata_i[32*k +: 32];
                r.pending = fwd_pending_i[k];
            end
        end
        if (addr == 5'd0) r = '{pending: 1'b0, data: 32'h0};
        return r;
    endfunction

    assign op1       = resolve(reg1_addr_o, reg1_data_i);
    assign op2       = resolve(reg2_addr_o, reg2_data_i);
    assign rs1_val_d = rs1_read ? op1.data : 32'h0;
    assign rs2_val_d = rs2_read ? op2.data : 32'h0;
    assign hazard    = (rs1_read && op1.pending) || (rs2_read && op2.pending);

    logic        out_valid_q, alt_q, wreg_q, illegal_q;
    logic [3:0]  op_class_q;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_val_q, rs2_val_q, imm_q, pc_q;
    logic [4:0]  rd_q;

    assign in_ready_o = !rst && !hazard && (!out_valid_q || out_ready_i);
    assign xfer       = in_valid_i && in_ready_o && !flush_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: the payload registers are reset too, so the held outputs are defined values right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_class_q  <= CLS_NOP;
            funct3_q    <= 3'h0;
            alt_q       <= 1'b0;
            rs1_val_q   <= 32'h0;
            rs2_val_q   <= 32'h0;
            imm_q       <= 32'h0;
            rd_q        <= 5'h0;
            wreg_q      <= 1'b0;
            pc_q        <= RESET_PC;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            op_class_q  <= class_d;
            funct3_q    <= funct3;
            alt_q       <= alt_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            rd_q        <= inst_i[11:7];
            wreg_q      <= wreg_d;
            pc_q        <= pc_i;
            illegal_q   <= illegal_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op_class_o  = op_class_q;
    assign funct3_o    = funct3_q;
    assign alt_o       = alt_q;
    assign rs1_val_o   = rs1_val_q;
    assign rs2_val_o   = rs2_val_q;
    assign imm_o       = imm_q;
    assign rd_o        = rd_q;
    assign wreg_o      = wreg_q;
    assign pc_o        = pc_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected decode results are queued on
// acceptance and compared when the stage hands the instruction to ex.
module tb_id_stage_pipe;

    localparam int          NF  = 2;
    localparam logic [31:0] RPC = 32'h0000_0080;

    logic              clk = 1'b0;
    logic              rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0]       pc_i, inst_i, reg1_data_i, reg2_data_i;
    logic [4:0]        reg1_addr_o, reg2_addr_o, rd_o;
    logic [NF-1:0]     fwd_wreg_i, fwd_pending_i;
    logic [5*NF-1:0]   fwd_wd_i;
    logic [32*NF-1:0]  fwd_wdata_i;
    logic [3:0]        op_class_o;
    logic [2:0]        funct3_o;
    logic              alt_o, wreg_o, illegal_o;
    logic [31:0]       rs1_val_o, rs2_val_o, imm_o, pc_o;

    id_stage_pipe #(.NUM_FWD(NF), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
        .fwd_pending_i(fwd_pending_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .op_class_o(op_class_o),
        .funct3_o(funct3_o), .alt_o(alt_o), .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o),
        .imm_o(imm_o), .rd_o(rd_o), .wreg_o(wreg_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] rs1, rs2, imm;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] pc;
        logic        ill;
        logic        full;
    } exp_t;

    exp_t sb[$];
    exp_t exp_next;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_wait;
    logic accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic exp_t mk(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [4:0] rd, input logic wreg, input logic [31:0] pc);
        exp_t e;
        e = '{cls: cls, f3: f3, alt: alt, rs1: rs1, rs2: rs2, imm: imm, rd: rd,
              wreg: wreg, pc: pc, ill: 1'b0, full: 1'b1};
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] pc);
        exp_t e;
        e = '{cls: 4'd0, f3: 3'd0, alt: 1'b0, rs1: 32'h0, rs2: 32'h0, imm: 32'h0, rd: 5'd0,
              wreg: 1'b0, pc: pc, ill: 1'b1, full: 1'b0};
        return e;
    endfunction

    task automatic cmp_out(input exp_t e);
        check("op_class", 32'(op_class_o), 32'(e.cls));
        check("wreg", 32'(wreg_o), 32'(e.wreg));
        check("illegal", 32'(illegal_o), 32'(e.ill));
        check("pc", pc_o, e.pc);
        if (e.full) begin
            check("funct3", 32'(funct3_o), 32'(e.f3));
            check("alt", 32'(alt_o), 32'(e.alt));
            check("rs1_val", rs1_val_o, e.rs1);
            check("rs2_val", rs2_val_o, e.rs2);
            check("imm", imm_o, e.imm);
            check("rd", 32'(rd_o), 32'(e.rd));
        end
    endtask

    // One cycle: sample mid-cycle, score drain/accept, advance past the edge.
    task automatic step();
        exp_t e;
        #2;
        accepted = in_valid_i && in_ready_o && !flush_i && !rst;
        if (!rst && out_valid_o && (out_ready_i || flush_i)) begin
            if (sb.size() == 0) check("sb_size", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                if (out_ready_i && !flush_i) cmp_out(e);
            end
        end
        if (accepted) sb.push_back(exp_next);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        int n;
        n          = 0;
        in_valid_i = 1'b1;
        inst_i     = inst;
        pc_i       = pc;
        exp_next   = e;
        do begin
            step();
            n++;
        end while (!accepted && n < 8);
        if (!accepted) check("accept", 32'(accepted), 32'd1);
        last_wait  = n;
        in_valid_i = 1'b0;
    endtask

    localparam logic [31:0] I_ADDI  = 32'hFFF0_0093;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;
    localparam logic [31:0] I_SW    = 32'h0020_A223;
    localparam logic [31:0] I_ADDI5 = 32'h0070_0293;
    localparam logic [31:0] I_BAD   = 32'h4200_D0B3;
    localparam logic [31:0] I_SRA   = 32'h4000_D0B3;
    localparam logic [31:0] I_SRAI  = 32'h4030_D093;

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        pc_i = 32'h0; inst_i = 32'h0; reg1_data_i = 32'h0; reg2_data_i = 32'h0;
        fwd_wreg_i = '0; fwd_pending_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
        exp_next = mk_ill(32'h0);

        repeat (2) @(posedge clk);
        #1;
        check("in_ready_in_rst", 32'(in_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_pc", pc_o, RPC);
        check("rst_class", 32'(op_class_o), 32'd0);
        check("rst_imm", imm_o, 32'h0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("in_ready_idle", 32'(in_ready_o), 32'd1);

        // ADDI x1,x0,-1 then ADD x3,x1,x2 with both sources matching rs1
        reg1_data_i = 32'hDEAD; reg2_data_i = 32'hBEEF;
        send(I_ADDI, 32'h100, mk(4'd8, 3'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h100));
        reg1_data_i = 32'd5; reg2_data_i = 32'd7;
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h9, 32'h1234};
        send(I_ADD, 32'h104, mk(4'd9, 3'd0, 1'b0, 32'h1234, 32'd7, 32'h0, 5'd3, 1'b1, 32'h104));
        check("reg1_addr", 32'(reg1_addr_o), 32'd1);
        check("reg2_addr", 32'(reg2_addr_o), 32'd2);

        // Load-use: youngest source writes x2 but its data is pending
        fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd2}; fwd_pending_i = 2'b01; fwd_wdata_i = '0;
        in_valid_i = 1'b1; inst_i = I_ADD; pc_i = 32'h108;
        exp_next = mk(4'd9, 3'd0, 1'b0, 32'd5, 32'h55, 32'h0, 5'd3, 1'b1, 32'h108);
        #1;
        check("hz_ready0", 32'(in_ready_o), 32'd0);
        check("hz_valid0", 32'(out_valid_o), 32'd1);
        step();
        #1;
        check("hz_ready1", 32'(in_ready_o), 32'd0);
        check("hz_valid1", 32'(out_valid_o), 32'd0);
        step();
        fwd_pending_i = 2'b00; fwd_wdata_i = {32'h0, 32'h55};
        send(I_ADD, 32'h108, exp_next);
        check("hz_release_wait", 32'(last_wait), 32'd1);

        // Branch, jump and a store using the older source only
        fwd_wreg_i = '0;
        send(I_BEQ, 32'h10C, mk(4'd5, 3'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd29, 1'b0, 32'h10C));
        send(I_JAL, 32'h110, mk(4'd3, 3'd0, 1'b0, 32'h0, 32'h0, 32'd8, 5'd1, 1'b1, 32'h110));
        check("tput", 32'(last_wait), 32'd1);
        reg1_data_i = 32'h1000; reg2_data_i = 32'h2222;
        fwd_wreg_i = 2'b10; fwd_wd_i = {5'd2, 5'd0}; fwd_wdata_i = {32'h77, 32'h0};
        send(I_SW, 32'h114, mk(4'd7, 3'd2, 1'b0, 32'h1000, 32'h77, 32'd4, 5'd4, 1'b0, 32'h114));
        fwd_wreg_i = '0;
        step();

        // Backpressure, then flush of the held entry and of a fresh input
        out_ready_i = 1'b0;
        send(I_ADDI5, 32'h118, mk(4'd8, 3'd0, 1'b0, 32'h0, 32'h0, 32'd7, 5'd5, 1'b1, 32'h118));
        in_valid_i = 1'b1; inst_i = I_JAL; pc_i = 32'h200;
        exp_next = mk(4'd3, 3'd0, 1'b0, 32'h0, 32'h0, 32'd8, 5'd1, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check("bp_ready", 32'(in_ready_o), 32'd0);
            check("bp_pc", pc_o, 32'h118);
            check("bp_imm", imm_o, 32'd7);
            step();
        end
        flush_i = 1'b1;
        step();
        #1;
        check("flush_valid", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b1;
        check("flush_ready", 32'(in_ready_o), 32'd1);
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        #1;
        check("flush_drop", 32'(out_valid_o), 32'd0);

        // Illegal funct7, then SRA and SRAI
        reg1_data_i = 32'hABC;
        send(I_BAD, 32'h120, mk_ill(32'h120));
        send(I_SRA, 32'h124, mk(4'd9, 3'd5, 1'b1, 32'hABC, 32'h0, 32'h0, 5'd1, 1'b1, 32'h124));
        send(I_SRAI, 32'h128, mk(4'd8, 3'd5, 1'b1, 32'hABC, 32'h0, 32'd3, 5'd1, 1'b1, 32'h128));
        repeat (2) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
